// File: rtl/csi2_vc_rr_scheduler.sv
// csi2_vc_rr_scheduler
//   Four-requester round-robin packet scheduler for the CSI-2 4-to-1 merge
//   path. Hands the TX packet engine to one header buffer per packet. A short
//   packet is held until its header is accepted. A long packet is held until
//   xfrdone. Each packet is tagged with VC = requester index, and a minimum
//   idle gap follows each packet.
//
//   Optional feature macro: CSI2_SCHED_TIMEOUT_EN adds an XFER watchdog that
//   aborts a long packet after TIMEOUT_CYC cycles. Without the macro,
//   timeout_o is tied 0.
//
// Ports
//   clk_i, rst_i   TX byte clock, async active-high reset
//   req_i          per-buffer packet request (level, held until gnt)
//   wdcnt_i        per-buffer word count / short data, WC_W bits each
//   dtype_i        per-buffer data type, 6 bits each
//   sptype_i       per-buffer short(1)/long(0) flag
//   xfrdone_i      per-buffer long-packet payload done pulse
//   c2d_rdy_i      TX engine can take a header
//   c2d_req_o      header valid to TX engine
//   wdcnt_o, dtype_o, vc_o, sptype_o   latched header of the granted buffer
//   lp_start_o     pulse: long-packet header accepted
//   gnt_o          one-hot grant, held for the whole packet
//   busy_o         scheduler not idle
//   timeout_o      pulse on watchdog abort
module csi2_vc_rr_scheduler #(
   parameter int NREQ        = 4,
   parameter int WC_W        = 16,
   parameter int SP_GAP      = 2,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*WC_W-1:0] wdcnt_i,
   input  logic [NREQ*6-1:0]    dtype_i,
   input  logic [NREQ-1:0]      sptype_i,
   input  logic [NREQ-1:0]      xfrdone_i,
   input  logic                 c2d_rdy_i,
   output logic                 c2d_req_o,
   output logic [WC_W-1:0]      wdcnt_o,
   output logic [5:0]           dtype_o,
   output logic [1:0]           vc_o,
   output logic                 sptype_o,
   output logic                 lp_start_o,
   output logic [NREQ-1:0]      gnt_o,
   output logic                 busy_o,
   output logic                 timeout_o
);

   typedef enum logic [2:0] {IDLE, ARB, HDR, XFER, GAP} state_t;

   localparam int GW = (SP_GAP > 1) ? $clog2(SP_GAP) : 1;

   state_t          state, nxt, end_st;
   logic [1:0]      ptr;
   logic [1:0]      win;
   logic            win_vld;
   logic [GW-1:0]   gap_cnt;
   logic            xfr_done;
   logic            to_hit;

   // With no gap configured, a finished packet returns straight to IDLE.
   assign end_st   = (SP_GAP == 0) ? IDLE : GAP;
   assign xfr_done = xfrdone_i[vc_o];

   // Round-robin search starting one past the last winner. The 2-bit index
   // wraps, so i == NREQ revisits the last winner itself.
   always_comb begin
      logic [1:0] idx;
      win_vld = 1'b0;
      win     = ptr;
      for (int i = 1; i <= NREQ; i++) begin
         idx = ptr + 2'(i);
         if (!win_vld && req_i[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

`ifdef CSI2_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] xfer_cnt;

   // The counter is zero on the first XFER cycle, so the abort lands
   // TIMEOUT_CYC cycles after XFER entry. A done pulse on the same cycle wins.
   assign to_hit    = (state == XFER) && (xfer_cnt == TW'(TIMEOUT_CYC)) && !xfr_done;
   assign timeout_o = to_hit;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)               xfer_cnt <= '0;
      else if (state != XFER)  xfer_cnt <= '0;
      else                     xfer_cnt <= xfer_cnt + 1'b1;
   end
`else
   assign to_hit    = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (|req_i) nxt = ARB;
         ARB:     nxt = win_vld ? HDR : IDLE;
         HDR:     if (c2d_rdy_i) nxt = sptype_o ? end_st : XFER;
         XFER:    if (xfr_done || to_hit) nxt = end_st;
         GAP:     if (gap_cnt == '0) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= nxt;
   end

   // Header latch, grant, pointer and gap counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr      <= 2'd3;
         wdcnt_o  <= '0;
         dtype_o  <= '0;
         vc_o     <= '0;
         sptype_o <= 1'b0;
         gnt_o    <= '0;
         gap_cnt  <= '0;
      end else begin
         if (state == ARB && win_vld) begin
            ptr      <= win;
            vc_o     <= win;
            wdcnt_o  <= wdcnt_i[int'(win)*WC_W +: WC_W];
            dtype_o  <= dtype_i[int'(win)*6 +: 6];
            sptype_o <= sptype_i[win];
            gnt_o    <= NREQ'(1) << win;
         end
         // The grant ends when the packet ends. HDR->XFER keeps it.
         if ((state == HDR || state == XFER) && nxt != state && nxt != XFER)
            gnt_o <= '0;
         if (nxt == GAP && state != GAP)
            gap_cnt <= GW'(SP_GAP - 1);
         else if (state == GAP && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
      end
   end

   assign c2d_req_o  = (state == HDR);
   assign lp_start_o = (state == HDR) && c2d_rdy_i && !sptype_o;
   assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_csi2_vc_rr_scheduler.sv
// Bench for csi2_vc_rr_scheduler. The model keeps a pending-request mask and
// the last winner. The next winner is the first pending index after the last
// winner, counted mod 4. Header fields are compared with the values the bench
// drove.
module tb_csi2_vc_rr_scheduler;

   localparam int SP_GAP = 2;
`ifdef CSI2_SCHED_TIMEOUT_EN
   localparam int TO_CYC = 100;
`else
   localparam int TO_CYC = 65535;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_i = '0;
   logic [63:0] wdcnt_i = '0;
   logic [23:0] dtype_i = '0;
   logic [3:0]  sptype_i = '0;
   logic [3:0]  xfrdone_i = '0;
   logic        c2d_rdy_i = 1'b0;
   logic        c2d_req_o;
   logic [15:0] wdcnt_o;
   logic [5:0]  dtype_o;
   logic [1:0]  vc_o;
   logic        sptype_o, lp_start_o, busy_o, timeout_o;
   logic [3:0]  gnt_o;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [3:0]  pend = '0;
   int          last = 3;
   logic [15:0] m_wd [4];
   logic [5:0]  m_dt [4];
   bit          m_sp [4];

   csi2_vc_rr_scheduler #(.NREQ(4), .WC_W(16), .SP_GAP(SP_GAP), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req_i), .wdcnt_i(wdcnt_i), .dtype_i(dtype_i),
      .sptype_i(sptype_i), .xfrdone_i(xfrdone_i), .c2d_rdy_i(c2d_rdy_i),
      .c2d_req_o(c2d_req_o), .wdcnt_o(wdcnt_o), .dtype_o(dtype_o), .vc_o(vc_o),
      .sptype_o(sptype_o), .lp_start_o(lp_start_o), .gnt_o(gnt_o), .busy_o(busy_o),
      .timeout_o(timeout_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_next();
      for (int i = 1; i <= 4; i++)
         if (pend[(last + i) % 4]) return (last + i) % 4;
      return -1;
   endfunction

   task automatic set_req(input int k, input bit sp, input logic [15:0] wd, input logic [5:0] dt);
      m_wd[k] = wd; m_dt[k] = dt; m_sp[k] = sp;
      wdcnt_i[k*16 +: 16] = wd;
      dtype_i[k*6 +: 6]   = dt;
      sptype_i[k]         = sp;
      pend[k]             = 1'b1;
      req_i               = pend;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_wdcnt", 32'(wdcnt_o), 0);
      chk("rst_ctl", 32'({c2d_req_o, dtype_o, vc_o, sptype_o, lp_start_o, gnt_o, busy_o, timeout_o}), 0);
      @(negedge clk);
      rst  = 1'b0;
      last = 3;
   endtask

   // One complete packet. rdy_dly counts HDR cycles with rdy low. xfer_dly
   // counts XFER cycles before done. spur sends xfrdone pulses on the other
   // buffers. mid_rst resets inside XFER. to_test waits for the watchdog.
   task automatic do_packet(input int rdy_dly, input int xfer_dly, input bit spur,
                            input bit mid_rst, input bit to_test, output int w);
      bit seen = 0;
      int n;
      w = model_next();
      for (n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (gnt_o != 0) seen = 1;
      end
      chk("gnt_wait", 32'(seen), 1);
      chk("gnt", 32'(gnt_o), 32'(1 << w));
      chk("vc", 32'(vc_o), 32'(w));
      chk("hdr_wdcnt", 32'(wdcnt_o), 32'(m_wd[w]));
      chk("hdr_dtype", 32'(dtype_o), 32'(m_dt[w]));
      chk("hdr_sptype", 32'(sptype_o), 32'(m_sp[w]));
      last    = w;
      pend[w] = 1'b0;
      req_i   = pend;
      for (int k = 0; k < rdy_dly; k++) begin
         chk("hdr_hold_req", 32'({c2d_req_o, lp_start_o}), 32'b10);
         chk("hdr_hold_wd", 32'(wdcnt_o), 32'(m_wd[w]));
         @(negedge clk);
      end
      c2d_rdy_i = 1'b1;
      #1;
      chk("accept_req", 32'(c2d_req_o), 1);
      chk("lp_start", 32'(lp_start_o), 32'(!m_sp[w]));
      @(negedge clk);
      c2d_rdy_i = 1'b0;
      chk("post_accept", 32'({c2d_req_o, lp_start_o}), 0);
      if (!m_sp[w]) begin
         chk("xfer_gnt", 32'(gnt_o), 32'(1 << w));
         if (to_test) begin
            n = 0;
            while (!timeout_o && n < 200) begin @(negedge clk); n++; end
            chk("timeout_lat", 32'(n), 32'(TO_CYC));
         end else begin
            for (int k = 0; k < xfer_dly; k++) @(negedge clk);
            if (spur) begin
               xfrdone_i = ~(4'(1) << w);
               @(negedge clk);
               xfrdone_i = '0;
               chk("spur_gnt", 32'({busy_o, gnt_o}), 32'({1'b1, 4'(1) << w}));
               @(negedge clk);
               chk("spur_gnt2", 32'(gnt_o), 32'(1 << w));
            end
            if (mid_rst) begin
               do_reset();
               return;
            end
            xfrdone_i = 4'(1) << w;
            @(negedge clk);
            xfrdone_i = '0;
         end
      end
      chk("end_gnt", 32'({gnt_o, busy_o, timeout_o}), 32'b00010);
      for (int k = 0; k < SP_GAP; k++) @(negedge clk);
      chk("gap_idle", 32'(busy_o), 0);
   endtask

   initial begin
      int w;
      @(negedge clk);
      do_reset();

      // 1: single short packet on buffer 0
      set_req(0, 1'b1, 16'h0001, 6'h00);
      do_packet(0, 0, 0, 0, 0, w);

      // 2: all four long; the winner re-requests immediately.
      // Expected order: 0,1,2,3,0.
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, 1'b0, 16'(100 + k), 6'h2a);
      for (int p = 0; p < 5; p++) begin
         do_packet(0, 10, 0, 0, 0, w);
         chk("rr_order", 32'(w), 32'(p % 4));
         if (p < 4) set_req(w, 1'b0, 16'(200 + p), 6'h2b);
      end
      pend = '0; req_i = '0;
      do_reset();

      // 3: long on buffer 2, rdy held low for 5 HDR cycles, zero word count
      set_req(2, 1'b0, 16'h0000, 6'h24);
      do_packet(5, 3, 0, 0, 0, w);

      // 4: XFER for buffer 1 ignores xfrdone on other buffers
      set_req(1, 1'b0, 16'h0040, 6'h1e);
      do_packet(0, 4, 1, 0, 0, w);

      // 5: reset in XFER, then buffer 0 wins first again
      set_req(2, 1'b0, 16'h0123, 6'h2c);
      set_req(0, 1'b1, 16'hbeef, 6'h12);
      do_packet(1, 2, 0, 1, 0, w);
      do_packet(0, 0, 0, 0, 0, w);
      chk("after_rst_win", 32'(w), 0);

`ifdef CSI2_SCHED_TIMEOUT_EN
      // 6: watchdog abort, then the grant moves on to the next buffer
      set_req(3, 1'b0, 16'h0010, 6'h2a);
      set_req(0, 1'b1, 16'h0011, 6'h01);
      do_packet(0, 0, 0, 0, 1, w);
      do_packet(0, 0, 0, 0, 0, w);
      chk("after_to_win", 32'(w), 0);
`endif

      // randomized traffic
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < 4; k++)
            if (!pend[k] && $urandom_range(0, 2) == 0)
               set_req(k, 1'($urandom), 16'($urandom), 6'($urandom));
         if (pend == 0)
            set_req(int'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 6'($urandom));
         do_packet(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                   1'($urandom), 0, 0, w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
